// File: rtl/rx_link_fault_detect.sv
// rx_link_fault_detect: Reconciliation-sublayer link fault monitor.
// Watches the raw 64-bit XGMII receive stream (two columns per cycle) for
// Sequence ordered sets and maintains the 2-bit link_fault status using the
// Clause 46 counting rules. Column A (lanes 0-3) is processed before column B
// (lanes 4-7) within each cycle, so B sees the state A left behind.
module rx_link_fault_detect #(
  parameter int COL_WINDOW = 128,
  parameter int SEQ_THRESH = 4
) (
  input  logic        rxclk,
  input  logic        reset,
  input  logic [63:0] rxd64,
  input  logic [7:0]  rxc8,
  output logic [1:0]  link_fault,
  output logic        fault_change,
  output logic        seq_seen
);

  // Column counter is wide enough to reach COL_WINDOW-1; the sequence counter
  // only has to hold 0..SEQ_THRESH because it saturates.
  localparam int CW = (COL_WINDOW > 2) ? $clog2(COL_WINDOW) : 1;
  localparam int SW = $clog2(SEQ_THRESH + 1);

  localparam logic [CW-1:0] COL_LAST   = CW'(COL_WINDOW - 1);
  localparam logic [SW-1:0] SEQ_MAX    = SW'(SEQ_THRESH);
  localparam logic [SW-1:0] SEQ_ONE    = SW'(1);
  localparam logic [CW-1:0] COL_ONE    = CW'(1);

  // Status FSM; the encoding is the link_fault output value itself.
  typedef enum logic [1:0] {
    LF_OK     = 2'b00,
    LF_LOCAL  = 2'b10,
    LF_REMOTE = 2'b11
  } fault_state_t;

  // Decode of one XGMII column.
  typedef struct packed {
    logic is_seq;    // valid Sequence ordered set
    logic seq_type;  // 0 = local fault, 1 = remote fault
  } col_dec_t;

  // Complete counting state carried from column to column.
  typedef struct packed {
    logic [CW-1:0] col_cnt;
    logic [SW-1:0] seq_cnt;
    logic          last_type;
    fault_state_t  link_fault;
  } mon_state_t;

  // Recognise a Sequence column: lane0 = control 0x9C, lanes 1-3 data,
  // lane1 = lane2 = 0x00, lane3 selects local (0x01) or remote (0x02).
  function automatic col_dec_t decode_col(input logic [31:0] d, input logic [3:0] c);
    col_dec_t r;
    r = '0;
    if ((c == 4'b0001) && (d[7:0] == 8'h9C) && (d[15:8] == 8'h00) && (d[23:16] == 8'h00)) begin
      case (d[31:24])
        8'h01: begin
          r.is_seq   = 1'b1;
          r.seq_type = 1'b0;
        end
        8'h02: begin
          r.is_seq   = 1'b1;
          r.seq_type = 1'b1;
        end
        default: begin
          r = '0;
        end
      endcase
    end else begin
      r = '0;
    end
    return r;
  endfunction

  // Apply the counting rules for one column to the running state.
  function automatic mon_state_t step_col(input mon_state_t s, input col_dec_t col);
    mon_state_t    n;
    logic [CW-1:0] col_nxt;
    n       = s;
    col_nxt = s.col_cnt + COL_ONE;
    if (col.is_seq) begin
      // Any Sequence restarts the idle window.
      n.col_cnt = '0;
      if ((s.seq_cnt != '0) && (col.seq_type == s.last_type)) begin
        if (s.seq_cnt >= SEQ_MAX) begin
          n.seq_cnt = SEQ_MAX;
        end else begin
          n.seq_cnt = s.seq_cnt + SEQ_ONE;
        end
      end else begin
        // New or different type: restart the run but keep the current status.
        n.seq_cnt   = SEQ_ONE;
        n.last_type = col.seq_type;
      end
      if (n.seq_cnt == SEQ_MAX) begin
        n.link_fault = n.last_type ? LF_REMOTE : LF_LOCAL;
      end else begin
        n.link_fault = s.link_fault;
      end
    end else begin
      if (col_nxt == COL_LAST) begin
        // Window expired without a Sequence: drop count and clear the fault.
        n.col_cnt    = '0;
        n.seq_cnt    = '0;
        n.link_fault = LF_OK;
      end else begin
        n.col_cnt    = col_nxt;
        n.link_fault = s.link_fault;
      end
    end
    return n;
  endfunction

  logic [CW-1:0] col_cnt_q,      col_cnt_d;
  logic [SW-1:0] seq_cnt_q,      seq_cnt_d;
  logic          last_type_q,    last_type_d;
  fault_state_t  link_fault_q,   link_fault_d;
  logic          fault_change_q, fault_change_d;
  logic          seq_seen_q,     seq_seen_d;

  col_dec_t   dec_a_s;
  col_dec_t   dec_b_s;
  mon_state_t st_cur_s;
  mon_state_t st_a_s;
  mon_state_t st_b_s;

  // Evaluate column A then column B and derive the next register values.
  always_comb begin
    dec_a_s  = decode_col(rxd64[31:0],  rxc8[3:0]);
    dec_b_s  = decode_col(rxd64[63:32], rxc8[7:4]);

    st_cur_s.col_cnt    = col_cnt_q;
    st_cur_s.seq_cnt    = seq_cnt_q;
    st_cur_s.last_type  = last_type_q;
    st_cur_s.link_fault = link_fault_q;

    st_a_s = step_col(st_cur_s, dec_a_s);
    st_b_s = step_col(st_a_s,   dec_b_s);

    col_cnt_d      = st_b_s.col_cnt;
    seq_cnt_d      = st_b_s.seq_cnt;
    last_type_d    = st_b_s.last_type;
    link_fault_d   = st_b_s.link_fault;
    fault_change_d = (st_b_s.link_fault != link_fault_q);
    seq_seen_d     = dec_a_s.is_seq | dec_b_s.is_seq;
  end

  // State and registered status outputs; reset discards any partial count.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      col_cnt_q      <= '0;
      seq_cnt_q      <= '0;
      last_type_q    <= 1'b0;
      link_fault_q   <= LF_OK;
      fault_change_q <= 1'b0;
      seq_seen_q     <= 1'b0;
    end else begin
      col_cnt_q      <= col_cnt_d;
      seq_cnt_q      <= seq_cnt_d;
      last_type_q    <= last_type_d;
      link_fault_q   <= link_fault_d;
      fault_change_q <= fault_change_d;
      seq_seen_q     <= seq_seen_d;
    end
  end

  assign link_fault   = link_fault_q;
  assign fault_change = fault_change_q;
  assign seq_seen     = seq_seen_q;

endmodule

// File: tb/tb_rx_link_fault_detect.sv
// Scoreboard bench for rx_link_fault_detect: the driver applies directed and
// random XGMII columns and pushes the reference model's expected outputs; a
// monitor pops one entry per clock and compares.
module tb_rx_link_fault_detect;
  localparam int COL_WINDOW = 128;
  localparam int SEQ_THRESH = 4;

  logic        rxclk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] rxd64 = 64'h0707070707070707;
  logic [7:0]  rxc8  = 8'hFF;
  logic [1:0]  link_fault;
  logic        fault_change;
  logic        seq_seen;

  rx_link_fault_detect #(.COL_WINDOW(COL_WINDOW), .SEQ_THRESH(SEQ_THRESH)) dut (
    .rxclk(rxclk), .reset(reset), .rxd64(rxd64), .rxc8(rxc8),
    .link_fault(link_fault), .fault_change(fault_change), .seq_seen(seq_seen)
  );

  always #5 rxclk = ~rxclk;

  // Reference model: run length of same-type Sequences, idle-column gap,
  // and current status (0 = OK, 2 = local, 3 = remote).
  int m_run, m_type, m_gap, m_fault;
  logic [3:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  bit active   = 1'b0;
  int cyc      = 0;

  // Column kinds: 0 idle, 1 local seq, 2 remote seq, 3 lane3=03,
  // 4 lane1=01, 5 extra control bit, other = random bits.
  function automatic logic [35:0] make_col(input int kind);
    logic [35:0] r;
    case (kind)
      0: r = {4'hF, 32'h07070707};
      1: r = {4'h1, 32'h0100009C};
      2: r = {4'h1, 32'h0200009C};
      3: r = {4'h1, 32'h0300009C};
      4: r = {4'h1, 32'h0100019C};
      5: r = {4'h3, 32'h0100009C};
      default: r = {4'($urandom), 32'($urandom)};
    endcase
    return r;
  endfunction

  // 0 = not a Sequence, 1 = local, 2 = remote
  function automatic int seq_kind(input logic [35:0] col);
    logic [7:0] b [4];
    logic [3:0] c;
    c = col[35:32];
    for (int i = 0; i < 4; i++) b[i] = col[8*i +: 8];
    if (c != 4'b0001 || b[0] != 8'h9C || b[1] != 8'h00 || b[2] != 8'h00) return 0;
    if (b[3] == 8'h01) return 1;
    if (b[3] == 8'h02) return 2;
    return 0;
  endfunction

  task automatic model_col(input logic [35:0] col, inout bit seen);
    int k;
    k = seq_kind(col);
    if (k != 0) begin
      seen  = 1'b1;
      m_gap = 0;
      if (m_run > 0 && k == m_type) m_run = m_run + 1;
      else begin
        m_run  = 1;
        m_type = k;
      end
      if (m_run >= SEQ_THRESH) m_fault = (k == 2) ? 3 : 2;
    end else begin
      m_gap = m_gap + 1;
      if (m_gap == COL_WINDOW - 1) begin
        m_gap   = 0;
        m_run   = 0;
        m_fault = 0;
      end
    end
  endtask

  task automatic drive_cycle(input int ka, input int kb);
    logic [35:0] a, b;
    int old;
    bit seen;
    a = make_col(ka);
    b = make_col(kb);
    @(negedge rxclk);
    reset = 1'b0;
    rxc8  = {b[35:32], a[35:32]};
    rxd64 = {b[31:0],  a[31:0]};
    old   = m_fault;
    seen  = 1'b0;
    model_col(a, seen);
    model_col(b, seen);
    exp_q.push_back({2'(m_fault), (m_fault != old), seen});
    active = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge rxclk);
    reset = 1'b1;
    rxc8  = 8'hFF;
    rxd64 = 64'h0707070707070707;
    m_run = 0; m_type = 0; m_gap = 0; m_fault = 0;
    #1;
    n_checks++;
    if ({link_fault, fault_change, seq_seen} !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset: got lf=%b fc=%b ss=%b expected lf=00 fc=0 ss=0",
               link_fault, fault_change, seq_seen);
    end
    exp_q.push_back(4'b0000);
    active = 1'b1;
  endtask

  task automatic repeat_cycles(input int n, input int ka, input int kb);
    for (int i = 0; i < n; i++) drive_cycle(ka, kb);
  endtask

  // Monitor: one expected entry per clock once stimulus has started.
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge rxclk);
      #1;
      cyc++;
      if (active) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_underflow: cycle %0d had no expected entry", cyc);
        end else begin
          e = exp_q.pop_front();
          if ({link_fault, fault_change, seq_seen} !== e) begin
            n_fail++;
            $display("FAIL outputs cycle %0d: got lf=%b fc=%b ss=%b expected lf=%b fc=%b ss=%b",
                     cyc, link_fault, fault_change, seq_seen, e[3:2], e[1], e[0]);
          end
        end
      end
    end
  end

  initial begin
    int mode, len;
    m_run = 0; m_type = 0; m_gap = 0; m_fault = 0;
    do_reset();
    do_reset();
    repeat_cycles(300, 0, 0);             // idle stream, window expiries silent
    repeat_cycles(4, 1, 1);               // local qualification
    repeat_cycles(3, 2, 2);               // remote preemption
    repeat_cycles(64, 0, 0);              // window expiry
    repeat_cycles(2, 1, 1);
    repeat_cycles(63, 0, 0);              // just short of expiry
    repeat_cycles(1, 1, 1);               // fault held
    repeat_cycles(70, 0, 0);
    repeat_cycles(4, 1, 2);               // mixed A local / B remote
    repeat_cycles(3, 3, 3);               // invalid lane3
    repeat_cycles(3, 4, 4);               // invalid lane1
    repeat_cycles(3, 5, 5);               // invalid control pattern
    drive_cycle(1, 1);                    // partial count, then reset
    do_reset();
    drive_cycle(1, 1);
    repeat_cycles(3, 0, 0);
    for (int burst = 0; burst < 150; burst++) begin
      mode = $urandom_range(0, 5);
      len  = $urandom_range(1, 12);
      case (mode)
        0: repeat_cycles($urandom_range(1, 80), 0, 0);
        1: repeat_cycles(len, 1, 1);
        2: repeat_cycles(len, 2, 2);
        3: for (int i = 0; i < len; i++) drive_cycle($urandom_range(0, 6), $urandom_range(0, 6));
        4: begin
          repeat_cycles(2, 2, 2);
          drive_cycle($urandom_range(0, 1) == 0 ? 2 : 0, 2);
          drive_cycle(2, 0);
          repeat_cycles($urandom_range(61, 65), 0, 0);
        end
        default: if ($urandom_range(0, 3) == 0) do_reset(); else drive_cycle(1, 2);
      endcase
    end
    @(posedge rxclk);
    #2;
    active = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
